// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider, exact 50% duty for odd and even N; optional tick port (CLK_DIV_PROG_TICK_EN).
// Latency: clk_out rises on the posedge entering RUN; a new divisor applies at the next period boundary, or at once in IDLE.
// Backpressure: none; div_load is accepted any cycle, a later load overwrites a staged one, 0/1 are rejected with div_err.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             div_en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic             clk_out
`ifdef CLK_DIV_PROG_TICK_EN
    ,
    output logic             tick
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [WIDTH-1:0] DEF_N  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_W1 = (WIDTH+1)'(1);

    state_t           state, state_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] n_act, n_next;
    logic [WIDTH-1:0] stage_val, stage_val_next;
    logic             stage_vld, stage_vld_next;
    logic             ack_next, err_next;
    logic             pos_q, pos_next;
    logic             neg_q;
    logic             boundary;
    logic             load_ok, load_bad;
    logic [WIDTH:0]   half_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            n_act     <= DEF_N;
            stage_val <= '0;
            stage_vld <= 1'b0;
            div_ack   <= 1'b0;
            div_err   <= 1'b0;
            pos_q     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            n_act     <= n_next;
            stage_val <= stage_val_next;
            stage_vld <= stage_vld_next;
            div_ack   <= ack_next;
            div_err   <= err_next;
            pos_q     <= pos_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        n_next         = n_act;
        stage_val_next = stage_val;
        stage_vld_next = stage_vld;
        ack_next       = 1'b0;
        err_next       = 1'b0;
        pos_next       = 1'b0;
        half_n         = '0;

        boundary = (state != IDLE) && (cnt == n_act - ONE);
        load_ok  = div_load && (div_val > ONE);
        load_bad = div_load && !(div_val > ONE);

        case (state)
            IDLE:    if (div_en) state_next = RUN;
            RUN:     if (!div_en) state_next = STOP;
            STOP: begin
                if (div_en)        state_next = RUN;
                else if (boundary) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (state == IDLE || state_next == IDLE || boundary)
            cnt_next = '0;
        else
            cnt_next = cnt + ONE;

        // The staged value applies before a same-cycle load is staged, so a load on the boundary waits a full period.
        if ((state == IDLE || boundary) && stage_vld) begin
            n_next         = stage_val;
            ack_next       = 1'b1;
            stage_vld_next = 1'b0;
        end

        if (load_ok) begin
            if (state == IDLE) begin
                n_next         = div_val;
                ack_next       = 1'b1;
                stage_vld_next = 1'b0;
            end else begin
                stage_val_next = div_val;
                stage_vld_next = 1'b1;
            end
        end

        err_next = load_bad;

        // Posedge phase is high for ceil(N/2) cycles; for odd N the negedge term trims the last half cycle.
        half_n   = ({1'b0, n_next} + ONE_W1) >> 1;
        pos_next = (state_next != IDLE) && ({1'b0, cnt_next} < half_n);
    end

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn)
            neg_q <= 1'b0;
        else
            neg_q <= !((state != IDLE) && n_act[0] && (cnt == (n_act >> 1)));
    end

`ifdef CLK_DIV_PROG_TICK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            tick <= 1'b0;
        else
            tick <= (state_next != IDLE) && (cnt_next == '0);
    end
`endif

    assign busy    = (state != IDLE);
    assign clk_out = pos_q & neg_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed bench for clk_div_prog; waveforms sampled every half clk period against hand-built patterns.
// Latency: checks are taken 1 time unit after each clock edge.
// Backpressure: not applicable; inputs are driven between edges.
module tb_clk_div_prog;

    logic       clk;
    logic       rstn;
    logic       div_en;
    logic       div_load;
    logic [7:0] div_val;
    logic       div_ack;
    logic       div_err;
    logic       busy;
    logic       clk_out;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] wc, wa, wb, wt;

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(5)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .div_en   (div_en),
        .div_load (div_load),
        .div_val  (div_val),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .busy     (busy),
        .clk_out  (clk_out)
`ifdef CLK_DIV_PROG_TICK_EN
        ,
        .tick     (tick)
`endif
    );

`ifndef CLK_DIV_PROG_TICK_EN
    assign tick = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First sample is taken immediately, then one after every clk edge; earliest sample ends up most significant.
    task automatic sample(input int nh);
        wc = '0; wa = '0; wb = '0; wt = '0;
        for (int i = 0; i < nh; i++) begin
            if (i > 0) begin
                @(clk);
                #1;
            end
            wc = {wc[62:0], clk_out};
            wa = {wa[62:0], div_ack};
            wb = {wb[62:0], busy};
            wt = {wt[62:0], tick};
        end
    endtask

    initial begin
        rstn     = 1'b0;
        div_en   = 1'b0;
        div_load = 1'b0;
        div_val  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_out", 64'(clk_out), 64'd0);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_ack",     64'(div_ack), 64'd0);
        check("rst_err",     64'(div_err), 64'd0);

        @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        check("idle_clk_out", 64'(clk_out), 64'd0);
        check("idle_busy",    64'(busy),    64'd0);

        // N=5 from reset default
        div_en = 1'b1;
        @(posedge clk);
        #1;
        check("first_rise", 64'(clk_out), 64'd1);
        check("run_busy",   64'(busy),    64'd1);
        sample(20);
        check("n5_wave", wc, 64'b11111000001111100000);
        check("n5_busy", wb, 64'hFFFFF);
`ifdef CLK_DIV_PROG_TICK_EN
        check("n5_tick", wt, 64'b11000000001100000000);
`endif

        // Load 4 mid-period: current N=5 period completes first
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        div_load = 1'b1;
        div_val  = 8'd4;
        @(posedge clk);
        #1;
        div_load = 1'b0;
        sample(22);
        check("n4_wave", wc, 64'b1000001111000011110000);
        check("n4_ack",  wa, 64'b0000001100000000000000);

        // div_val=1 rejected
        div_load = 1'b1;
        div_val  = 8'd1;
        @(posedge clk);
        #1;
        div_load = 1'b0;
        check("err1_pulse", 64'(div_err), 64'd1);
        check("err1_noack", 64'(div_ack), 64'd0);
        @(posedge clk);
        #1;
        check("err1_clear", 64'(div_err), 64'd0);
        sample(16);
        check("err1_wave_n4", wc, 64'b1100001111000011);
        check("err1_no_ack",  wa, 64'd0);

        // div_val=0 rejected
        div_load = 1'b1;
        div_val  = 8'd0;
        @(posedge clk);
        #1;
        div_load = 1'b0;
        check("err0_pulse", 64'(div_err), 64'd1);

        // N=6, drop div_en at cnt=1
        div_load = 1'b1;
        div_val  = 8'd6;
        @(posedge clk);
        #1;
        div_load = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("ack_n6", 64'(div_ack), 64'd1);
        @(posedge clk);
        #1;
        div_en = 1'b0;
        sample(14);
        check("stop_wave", wc, 64'b11110000000000);
        check("stop_busy", wb, 64'b11111111110000);

        // N=7 loaded in IDLE applies at once; reset during high phase
        div_load = 1'b1;
        div_val  = 8'd7;
        @(posedge clk);
        #1;
        div_load = 1'b0;
        check("ack_idle", 64'(div_ack), 64'd1);
        div_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_high", 64'(clk_out), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("rst_async_clk",  64'(clk_out), 64'd0);
        check("rst_async_busy", 64'(busy),    64'd0);
        @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rerun_rise", 64'(clk_out), 64'd1);
        sample(10);
        check("rst_default_n5", wc, 64'b1111100000);

        // Load 3 on the boundary cycle: deferred to the following boundary
        div_load = 1'b1;
        div_val  = 8'd3;
        @(posedge clk);
        #1;
        div_load = 1'b0;
        check("ack_defer", 64'(div_ack), 64'd0);
        sample(22);
        check("n3_wave", wc, 64'b1111100000111000111000);
        check("n3_ack",  wa, 64'b0000000000110000000000);
`ifdef CLK_DIV_PROG_TICK_EN
        check("n3_tick", wt, 64'b1100000000110000110000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
